gba_dsound_array: RTL and testbench
===================================

# gba_dsound_array

Parametrised direct-sound engine: NUM_CH independent 32-bit-word sample FIFOs, each drained one signed byte per overflow of a selectable timer, with per-channel DMA refill requests, 50%/100% volume and L/R routing, summed into left-aligned stereo outputs. It generalises the fixed two-channel FIFO A/B path of the audio top to arbitrary channel count, FIFO depth and output width, and adds underflow/overflow reporting and a master sound enable. It sits between the IO-register/DMA side and the final audio mixer, all on gba_clk.

## Interface
- NUM_CH, 2: number of direct-sound channels (1..8).
- FIFO_WORDS, 8: FIFO depth in 32-bit words per channel; power of two, >=4.
- NUM_TIMERS, 2: number of timer overflow inputs (>=2).
- OUT_W, 24: width of signed stereo outputs (>= 10 + clog2(NUM_CH)).

- gba_clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sound_en  in  1  master enable (SOUNDCNT_X bit 7); low acts as clear on every channel.
- fifo_wr  in  NUM_CH  one-cycle write strobe per channel.
- fifo_wdata  in  32  shared write word; byte 0 = bits [7:0] plays first.
- fifo_clr  in  NUM_CH  one-cycle clear strobe per channel.
- timer_ovf  in  NUM_TIMERS  one-cycle timer overflow pulses.
- timer_sel  in  NUM_CH*clog2(NUM_TIMERS)  timer index per channel.
- vol_full  in  NUM_CH  1 = 100%, 0 = 50%.
- en_l, en_r  in  NUM_CH each  route channel to left / right.
- dma_req  out  NUM_CH  one-cycle refill request.
- fifo_level  out  NUM_CH*clog2(FIFO_WORDS+1)  words held in FIFO (holding register excluded).
- underflow, overflow  out  NUM_CH each  one-cycle error pulses.
- sample_l, sample_r  out  OUT_W each  signed mixed output.

## Operation
- Per channel: FIFO of FIFO_WORDS words, plus holding register (up to 3 pending bytes, count 0..3) and current sample register (signed 8-bit).
- Write: fifo_wr with level < FIFO_WORDS pushes fifo_wdata; at level == FIFO_WORDS word dropped, overflow pulses, level unchanged.
- Tick = timer_ovf[timer_sel[ch]]. On tick: holding count > 0 -> next pending byte becomes sample, count-1; else FIFO non-empty -> pop word, byte0 becomes sample, bytes 1..3 to holding, count=3; else underflow pulses, sample held.
- Write and pop same cycle: both occur, level unchanged; write to full FIFO with pop same cycle is accepted.
- dma_req pulses on the cycle after any pop whose resulting level <= FIFO_WORDS/2.
- Clear (fifo_clr[ch] or !sound_en): FIFO level 0, holding count 0, sample 0; wins over simultaneous write and tick; no dma_req, underflow or overflow while sound_en low.
- Mix: term = sign_extend(sample) << vol_full (x2 at 100%); sum enabled terms per side in SAMPLE+2+clog2(NUM_CH) bits; output = sum <<< (OUT_W - 9 - clog2(NUM_CH)). No saturation needed; range fits by construction.
- Reset: FIFOs empty, all samples 0, all outputs 0.

## Timing
- Tick at edge N: sample register updated at N+1; sample_l/r registered, valid at N+2.
- dma_req, underflow asserted in the cycle after the tick edge (registered, one cycle wide); overflow registered one cycle after the dropped write.
- fifo_level reflects pushes/pops one cycle after the strobe.
- Reset deassertion takes effect synchronously to gba_clk via a two-flop synchroniser on the release edge only.

## Structure
- Package gba_dsound_pkg: SAMPLE_W=8, BYTES_PER_WORD=4, holding-count typedef, mix-shift function of OUT_W and NUM_CH.
- Sub-module gba_dsound_chan: one FIFO, holding register, tick/pop logic, dma/error pulses; instantiated NUM_CH times by generate. Timer select mux and stereo mixer live in the top.

## Test plan
- Reset, write 0x80_7F_01_FF to ch0 (vol_full=1, en_l=1), tick timer0 4x -> sample_l = -2<<14, 2<<14, 254<<14, -256<<14 each two cycles after its tick.
- Fill ch1 with 8 words, 9th write -> overflow pulse, fifo_level=8; 4 ticks drain one word -> level 7, no dma_req; drain to level 4 -> dma_req on each pop reaching <=4.
- Empty ch0, tick -> underflow pulse, sample held, no dma_req.
- Write and fifo_clr same cycle on ch0 -> level 0, sample 0, outputs 0 after two cycles.
- Both channels at 127, vol_full=1, en_l/en_r=1 -> sample_l = sample_r = 8323072; drop sound_en -> all outputs 0, no requests.
- NUM_CH=4, FIFO_WORDS=16 build: ch3 on timer1, ticks on timer0 only -> ch3 unchanged; dma_req at level <=8.

Source files
------------

// File: rtl/gba_dsound_pkg.sv
// Shared constants, types and helpers for the direct-sound channel array.
package gba_dsound_pkg;

    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Pending bytes still held after a word pop (0..3).
    typedef logic [1:0] hold_cnt_t;

    // Left shift that places the mixed sum at the top of an out_w-bit output.
    function automatic int unsigned mix_shift(input int unsigned out_w,
                                              input int unsigned num_ch);
        return out_w - (SAMPLE_W + 1) - $clog2(num_ch);
    endfunction

endpackage

// File: rtl/gba_dsound_chan.sv
// One direct-sound channel: word FIFO, byte holding register, current sample,
// and the registered DMA-request / underflow / overflow pulses.
module gba_dsound_chan
    import gba_dsound_pkg::*;
#(
    parameter int unsigned FIFO_WORDS = 8,
    localparam int unsigned AW        = $clog2(FIFO_WORDS),
    localparam int unsigned LVL_W     = $clog2(FIFO_WORDS + 1)
) (
    input  logic                       gba_clk,
    input  logic                       rst_n,
    input  logic                       sound_en,
    input  logic                       wr,
    input  logic [31:0]                wdata,
    input  logic                       clr,
    input  logic                       tick,
    output logic                       dma_req,
    output logic [LVL_W-1:0]           level,
    output logic                       underflow,
    output logic                       overflow,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [31:0]                mem_q [FIFO_WORDS];
    logic [AW-1:0]              rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0]           level_q, level_d;
    logic [23:0]                hold_q, hold_d;
    hold_cnt_t                  hold_cnt_q, hold_cnt_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       dma_req_q, underflow_q, overflow_q;

    logic        clear, empty, full, pop, push;
    logic [31:0] rd_word;

    // Pop/push decisions; clear (strobe or master disable) overrides everything.
    always_comb begin
        clear   = clr | ~sound_en;
        empty   = (level_q == '0);
        full    = (level_q == LVL_W'(FIFO_WORDS));
        rd_word = mem_q[rd_ptr_q];
        pop     = tick & ~clear & (hold_cnt_q == '0) & ~empty;
        // A pop in the same cycle frees a slot, so a write to a full FIFO is kept.
        push    = wr & ~clear & (~full | pop);
    end

    // Next FIFO level.
    always_comb begin
        level_d = level_q;
        if (clear) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Next sample and holding register: drain held bytes before popping a new word.
    always_comb begin
        sample_d   = sample_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        if (clear) begin
            sample_d   = '0;
            hold_d     = '0;
            hold_cnt_d = '0;
        end else if (tick) begin
            if (hold_cnt_q != '0) begin
                sample_d   = signed'(hold_q[7:0]);
                hold_d     = {8'h00, hold_q[23:8]};
                hold_cnt_d = hold_cnt_q - hold_cnt_t'(1);
            end else if (!empty) begin
                sample_d   = signed'(rd_word[7:0]);
                hold_d     = rd_word[31:8];
                hold_cnt_d = hold_cnt_t'(BYTES_PER_WORD - 1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge gba_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Channel state and registered status pulses.
    always_ff @(posedge gba_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            sample_q    <= '0;
            dma_req_q   <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            level_q    <= level_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            sample_q   <= sample_d;
            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
            dma_req_q   <= pop & (level_d <= LVL_W'(FIFO_WORDS / 2));
            underflow_q <= tick & ~clear & (hold_cnt_q == '0) & empty;
            overflow_q  <= wr & ~clear & full & ~pop;
        end
    end

    assign dma_req   = dma_req_q;
    assign level     = level_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign sample    = sample_q;

endmodule

// File: rtl/gba_dsound_array.sv
// Direct-sound engine: NUM_CH FIFO channels, per-channel timer select,
// volume/L-R routing and a registered stereo mixer.
module gba_dsound_array
    import gba_dsound_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_WORDS = 8,
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned OUT_W      = 24,
    localparam int unsigned TSEL_W    = $clog2(NUM_TIMERS),
    localparam int unsigned LVL_W     = $clog2(FIFO_WORDS + 1)
) (
    input  logic                       gba_clk,
    input  logic                       reset_n,
    input  logic                       sound_en,
    input  logic [NUM_CH-1:0]          fifo_wr,
    input  logic [31:0]                fifo_wdata,
    input  logic [NUM_CH-1:0]          fifo_clr,
    input  logic [NUM_TIMERS-1:0]      timer_ovf,
    input  logic [NUM_CH*TSEL_W-1:0]   timer_sel,
    input  logic [NUM_CH-1:0]          vol_full,
    input  logic [NUM_CH-1:0]          en_l,
    input  logic [NUM_CH-1:0]          en_r,
    output logic [NUM_CH-1:0]          dma_req,
    output logic [NUM_CH*LVL_W-1:0]    fifo_level,
    output logic [NUM_CH-1:0]          underflow,
    output logic [NUM_CH-1:0]          overflow,
    output logic signed [OUT_W-1:0]    sample_l,
    output logic signed [OUT_W-1:0]    sample_r
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SUM_W = SAMPLE_W + 2 + CH_W;
    localparam int unsigned SHIFT = mix_shift(OUT_W, NUM_CH);

    logic [1:0]                 rst_sync_q;
    logic                       rst_n;
    logic [NUM_CH-1:0]          ch_tick;
    logic signed [SAMPLE_W-1:0] ch_sample [NUM_CH];
    logic signed [SUM_W-1:0]    ch_term   [NUM_CH];
    logic signed [SUM_W-1:0]    sum_l, sum_r;
    logic signed [OUT_W-1:0]    sample_l_q, sample_r_q;

    // Assert asynchronously, release two edges after reset_n rises.
    always_ff @(posedge gba_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [TSEL_W-1:0]       sel;
        logic signed [SUM_W-1:0] ext;

        assign sel = timer_sel[c*TSEL_W +: TSEL_W];
        // Out-of-range selects (non power-of-two timer count) never tick.
        assign ch_tick[c] = (32'(sel) < NUM_TIMERS) ? timer_ovf[sel] : 1'b0;

        assign ext        = SUM_W'(ch_sample[c]);
        assign ch_term[c] = vol_full[c] ? (ext <<< 1) : ext;

        gba_dsound_chan #(
            .FIFO_WORDS (FIFO_WORDS)
        ) u_chan (
            .gba_clk   (gba_clk),
            .rst_n     (rst_n),
            .sound_en  (sound_en),
            .wr        (fifo_wr[c]),
            .wdata     (fifo_wdata),
            .clr       (fifo_clr[c]),
            .tick      (ch_tick[c]),
            .dma_req   (dma_req[c]),
            .level     (fifo_level[c*LVL_W +: LVL_W]),
            .underflow (underflow[c]),
            .overflow  (overflow[c]),
            .sample    (ch_sample[c])
        );
    end

    // Sum the routed channel terms per side.
    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en_l[c]) begin
                sum_l = sum_l + ch_term[c];
            end
            if (en_r[c]) begin
                sum_r = sum_r + ch_term[c];
            end
        end
    end

    // Registered, left-aligned stereo outputs.
    always_ff @(posedge gba_clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_l_q <= '0;
            sample_r_q <= '0;
        end else begin
            sample_l_q <= OUT_W'(sum_l) <<< SHIFT;
            sample_r_q <= OUT_W'(sum_r) <<< SHIFT;
        end
    end

    assign sample_l = sample_l_q;
    assign sample_r = sample_r_q;

endmodule

// File: tb/tb_gba_dsound_array.sv
// Scoreboard bench for gba_dsound_array: a default 2-channel instance and a
// 4-channel / 16-word instance, directed stimulus with hand-computed values.
module tb_gba_dsound_array;

    localparam int K_SL   = 0;
    localparam int K_SR   = 1;
    localparam int K_LVL  = 2;
    localparam int K_DMA  = 3;
    localparam int K_UDF  = 4;
    localparam int K_OVF  = 5;
    localparam int K_QSL  = 6;
    localparam int K_QLVL = 7;
    localparam int K_QDMA = 8;

    typedef struct {
        int          kind;
        int          ch;
        int          due;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic gba_clk = 1'b0;
    logic reset_n = 1'b0;
    logic sound_en = 1'b1;
    logic [31:0] fifo_wdata = '0;

    // Default build: 2 channels, 8 words, 2 timers, 24-bit outputs.
    logic [1:0]         fifo_wr = '0, fifo_clr = '0, timer_ovf = '0, timer_sel = '0;
    logic [1:0]         vol_full = '0, en_l = '0, en_r = '0;
    logic [1:0]         dma_req, underflow, overflow;
    logic [7:0]         fifo_level;
    logic signed [23:0] sample_l, sample_r;

    // Wide build: 4 channels, 16 words.
    logic [3:0]         q_fifo_wr = '0, q_fifo_clr = '0, q_timer_sel = '0;
    logic [1:0]         q_timer_ovf = '0;
    logic [3:0]         q_vol_full = '0, q_en_l = '0, q_en_r = '0;
    logic [3:0]         q_dma_req, q_underflow, q_overflow;
    logic [19:0]        q_fifo_level;
    logic signed [23:0] q_sample_l, q_sample_r;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mon_act;

    always #5 gba_clk = ~gba_clk;

    always @(posedge gba_clk) cyc <= cyc + 1;

    gba_dsound_array dut (
        .gba_clk    (gba_clk),
        .reset_n    (reset_n),
        .sound_en   (sound_en),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_clr   (fifo_clr),
        .timer_ovf  (timer_ovf),
        .timer_sel  (timer_sel),
        .vol_full   (vol_full),
        .en_l       (en_l),
        .en_r       (en_r),
        .dma_req    (dma_req),
        .fifo_level (fifo_level),
        .underflow  (underflow),
        .overflow   (overflow),
        .sample_l   (sample_l),
        .sample_r   (sample_r)
    );

    gba_dsound_array #(
        .NUM_CH     (4),
        .FIFO_WORDS (16),
        .NUM_TIMERS (2),
        .OUT_W      (24)
    ) dut4 (
        .gba_clk    (gba_clk),
        .reset_n    (reset_n),
        .sound_en   (sound_en),
        .fifo_wr    (q_fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_clr   (q_fifo_clr),
        .timer_ovf  (q_timer_ovf),
        .timer_sel  (q_timer_sel),
        .vol_full   (q_vol_full),
        .en_l       (q_en_l),
        .en_r       (q_en_r),
        .dma_req    (q_dma_req),
        .fifo_level (q_fifo_level),
        .underflow  (q_underflow),
        .overflow   (q_overflow),
        .sample_l   (q_sample_l),
        .sample_r   (q_sample_r)
    );

    function automatic logic [31:0] actual(input int kind, input int ch);
        case (kind)
            K_SL:    return 32'(sample_l);
            K_SR:    return 32'(sample_r);
            K_LVL:   return 32'(fifo_level[ch*4 +: 4]);
            K_DMA:   return 32'(dma_req);
            K_UDF:   return 32'(underflow);
            K_OVF:   return 32'(overflow);
            K_QSL:   return 32'(q_sample_l);
            K_QLVL:  return 32'(q_fifo_level[ch*5 +: 5]);
            K_QDMA:  return 32'(q_dma_req);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Queue an expectation lat rising edges after the current drive point.
    task automatic expect_at(input int kind, input int ch, input int lat,
                             input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.due  = cyc + lat;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due in the cycle just completed.
    always @(negedge gba_clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                mon_act = actual(sb[i].kind, sb[i].ch);
                if (mon_act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0d, expected %0d", sb[i].name, cyc,
                             $signed(mon_act), $signed(sb[i].exp));
                end
                sb.delete(i);
            end
        end
    end

    // Start a drive cycle: just after the falling edge, strobes default low.
    task automatic cyc_start();
        @(negedge gba_clk);
        #1;
        fifo_wr     = '0;
        fifo_clr    = '0;
        timer_ovf   = '0;
        q_fifo_wr   = '0;
        q_fifo_clr  = '0;
        q_timer_ovf = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_start();
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int samp_exp[4];
        int lvl;
        samp_exp[0] = -2 <<< 14;
        samp_exp[1] = 2 <<< 14;
        samp_exp[2] = 254 <<< 14;
        samp_exp[3] = -256 <<< 14;

        idle(3);
        reset_n = 1'b1;
        idle(4);

        // Reset state.
        cyc_start();
        expect_at(K_SL, 0, 1, 0, "reset_sample_l");
        expect_at(K_SR, 0, 1, 0, "reset_sample_r");
        expect_at(K_LVL, 0, 1, 0, "reset_level_ch0");
        expect_at(K_LVL, 1, 1, 0, "reset_level_ch1");
        expect_at(K_DMA, 0, 1, 0, "reset_dma_req");
        expect_at(K_QLVL, 3, 1, 0, "reset_wide_level_ch3");

        // Byte order and volume: one word played over four ticks on ch0.
        timer_sel = 2'b00;
        vol_full  = 2'b01;
        en_l      = 2'b01;
        en_r      = 2'b00;
        cyc_start();
        fifo_wr[0] = 1'b1;
        fifo_wdata = 32'h807F_01FF;
        expect_at(K_LVL, 0, 1, 1, "write_level_ch0");
        for (int i = 0; i < 4; i++) begin
            cyc_start();
            timer_ovf[0] = 1'b1;
            expect_at(K_SL, 0, 2, samp_exp[i], "byte_sample_l");
            if (i == 0) begin
                expect_at(K_DMA, 0, 1, 32'b01, "pop_to_empty_dma");
                expect_at(K_LVL, 0, 1, 0, "pop_level_ch0");
                expect_at(K_UDF, 0, 1, 32'b10, "ch1_empty_underflow");
            end else begin
                expect_at(K_DMA, 0, 1, 0, "held_byte_no_dma");
            end
        end
        idle(3);

        // Fill ch1, overflow on the ninth write; ch0 moved to timer1.
        timer_sel = 2'b01;
        for (int i = 0; i < 9; i++) begin
            cyc_start();
            fifo_wr[1] = 1'b1;
            fifo_wdata = 32'h1000_0000 + 32'(i);
            if (i < 8) begin
                expect_at(K_LVL, 1, 1, i + 1, "fill_level_ch1");
            end else begin
                expect_at(K_OVF, 0, 1, 32'b10, "overflow_pulse");
                expect_at(K_LVL, 1, 1, 8, "overflow_level_ch1");
            end
        end
        cyc_start();
        expect_at(K_OVF, 0, 1, 0, "overflow_one_cycle");
        expect_at(K_LVL, 1, 1, 8, "full_level_held");

        // Drain ch1: pops every fourth tick, requests once level <= 4.
        for (int j = 0; j < 20; j++) begin
            cyc_start();
            timer_ovf[0] = 1'b1;
            if (j % 4 == 0) begin
                lvl = 7 - j / 4;
                expect_at(K_LVL, 1, 1, lvl, "drain_level_ch1");
                expect_at(K_DMA, 0, 1, (lvl <= 4) ? 32'b10 : 32'b00, "drain_dma_req");
                expect_at(K_UDF, 0, 1, 0, "drain_no_underflow");
            end
        end
        idle(3);

        // Underflow on empty ch0: pulse, sample held, no request.
        cyc_start();
        timer_ovf[1] = 1'b1;
        expect_at(K_UDF, 0, 1, 32'b01, "underflow_pulse");
        expect_at(K_DMA, 0, 1, 0, "underflow_no_dma");
        expect_at(K_SL, 0, 2, -256 <<< 14, "underflow_sample_held");
        idle(3);

        // Clear wins over a simultaneous write.
        cyc_start();
        fifo_wr[0]  = 1'b1;
        fifo_clr[0] = 1'b1;
        fifo_wdata  = 32'h1234_5678;
        expect_at(K_LVL, 0, 1, 0, "clear_vs_write_level");
        expect_at(K_SL, 0, 2, 0, "clear_sample_zero");
        idle(3);

        // Both channels at +127, full volume, both sides.
        cyc_start();
        fifo_clr = 2'b11;
        timer_sel = 2'b00;
        vol_full  = 2'b11;
        en_l      = 2'b11;
        en_r      = 2'b11;
        cyc_start();
        fifo_wr    = 2'b11;
        fifo_wdata = 32'h7F7F_7F7F;
        expect_at(K_LVL, 0, 1, 1, "both_level_ch0");
        expect_at(K_LVL, 1, 1, 1, "both_level_ch1");
        cyc_start();
        timer_ovf[0] = 1'b1;
        expect_at(K_SL, 0, 2, 8323072, "max_sample_l");
        expect_at(K_SR, 0, 2, 8323072, "max_sample_r");
        expect_at(K_DMA, 0, 1, 32'b11, "both_dma_req");
        idle(2);

        // Master disable: clears everything and suppresses all pulses.
        cyc_start();
        sound_en     = 1'b0;
        timer_ovf[0] = 1'b1;
        fifo_wr      = 2'b11;
        expect_at(K_DMA, 0, 1, 0, "disable_no_dma");
        expect_at(K_UDF, 0, 1, 0, "disable_no_underflow");
        expect_at(K_OVF, 0, 1, 0, "disable_no_overflow");
        expect_at(K_LVL, 0, 1, 0, "disable_level_ch0");
        expect_at(K_LVL, 1, 1, 0, "disable_level_ch1");
        expect_at(K_SL, 0, 2, 0, "disable_sample_l");
        expect_at(K_SR, 0, 2, 0, "disable_sample_r");
        cyc_start();
        timer_ovf[0] = 1'b1;
        expect_at(K_UDF, 0, 1, 0, "disabled_tick_no_underflow");
        cyc_start();
        sound_en = 1'b1;
        idle(3);

        // Wide build: ch3 on timer1 is untouched by timer0 ticks.
        q_timer_sel = 4'b1000;
        q_en_l      = 4'b1000;
        q_vol_full  = 4'b0000;
        cyc_start();
        q_fifo_wr[3] = 1'b1;
        fifo_wdata   = 32'h0000_0005;
        expect_at(K_QLVL, 3, 1, 1, "wide_write_ch3");
        cyc_start();
        q_timer_ovf[1] = 1'b1;
        expect_at(K_QLVL, 3, 1, 0, "wide_pop_ch3");
        expect_at(K_QSL, 0, 2, 5 <<< 13, "wide_ch3_sample");
        for (int i = 0; i < 10; i++) begin
            cyc_start();
            q_fifo_wr[0] = 1'b1;
            fifo_wdata   = 32'h2000_0000 + 32'(i);
        end
        expect_at(K_QLVL, 0, 1, 10, "wide_fill_ch0");
        for (int j = 0; j < 8; j++) begin
            cyc_start();
            q_timer_ovf[0] = 1'b1;
            expect_at(K_QSL, 0, 2, 5 <<< 13, "wide_ch3_unchanged");
            if (j == 0) begin
                expect_at(K_QDMA, 0, 1, 0, "wide_level9_no_dma");
            end else if (j == 4) begin
                expect_at(K_QDMA, 0, 1, 32'b0001, "wide_level8_dma");
                expect_at(K_QLVL, 0, 1, 8, "wide_level8");
            end
        end
        idle(4);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
